// File: rtl/mu_sweep_ctrl.sv
// Wishbone-controlled delay-code sweep sequencer for one delay-line/comparator channel.
// Steps the code, fires strobe bursts per point, counts comparator hits into a result FIFO.
module mu_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned STB_HIGH_CYCLES = 4,
  parameter int unsigned CMP_LATENCY     = 2,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o,
  output logic [9:0]  delay_code_o,
  output logic        stb_o,
  input  logic        cmp_i,
  output logic        busy_o
);

  localparam int unsigned Period = 2 * STB_HIGH_CYCLES;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned SW     = $clog2(SETTLE_CYCLES) + 1;
  localparam int unsigned PW     = $clog2(Period) + 1;

  localparam logic [2:0] AdrCtrl   = 3'd0;
  localparam logic [2:0] AdrStatus = 3'd1;
  localparam logic [2:0] AdrRange  = 3'd2;
  localparam logic [2:0] AdrCfg    = 3'd3;
  localparam logic [2:0] AdrResult = 3'd4;

  localparam logic [31:0] RangeMask = 32'h03FF_03FF;
  localparam logic [31:0] CfgMask   = 32'hFFFF_03FF;

  typedef enum logic [2:0] {StIdle, StSettle, StShot, StPush, StNext} state_e;

  state_e          state_q;
  logic [2:0]      adr_q;
  logic            we_q;
  logic [3:0]      sel_q;
  logic [31:0]     dat_q;
  logic            pop_pend_q;
  logic [31:0]     range_q;
  logic [31:0]     cfg_q;
  logic            done_q;
  logic            range_err_q;
  logic [9:0]      code_q;
  logic [9:0]      run_stop_q;
  logic [9:0]      run_step_q;
  logic [15:0]     run_shots_q;
  logic [15:0]     hits_q;
  logic [15:0]     shot_q;
  logic [SW-1:0]   settle_cnt_q;
  logic [PW-1:0]   phase_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [25:0]     mem [FIFO_DEPTH];

  logic            req;
  logic            wr_now;
  logic            start_now;
  logic            abort_now;
  logic            pop_now;
  logic            push_now;
  logic            fifo_full;
  logic            fifo_empty;
  logic [25:0]     head;
  logic [7:0]      count8;
  logic [31:0]     status_w;
  logic [31:0]     rdata;
  logic [10:0]     next_code;
  logic [PW-1:0]   phase_inc;
  logic            unused_adr;

  assign wb_err_o   = 1'b0;
  assign wb_stall_o = 1'b0;
  assign busy_o     = (state_q != StIdle);
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  // Writes commit at the end of the ack cycle, using the request captured when ack was raised.
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_now    = wb_ack_o & we_q;
  assign start_now = wr_now && (adr_q == AdrCtrl) && sel_q[0] && dat_q[0] && (state_q == StIdle);
  assign abort_now = wr_now && (adr_q == AdrCtrl) && sel_q[0] && dat_q[1] && (state_q != StIdle);
  assign pop_now   = wb_ack_o & pop_pend_q;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push_now   = !wb_rst_i && (state_q == StPush) && !abort_now && (!fifo_full || pop_now);
  assign head       = mem[rd_ptr_q];
  assign count8     = 8'(count_q);
  assign status_w   = {16'h0, count8, 3'b000, range_err_q, fifo_full, fifo_empty, done_q, busy_o};
  assign next_code  = {1'b0, code_q} + {1'b0, run_step_q};
  assign phase_inc  = phase_q + PW'(1);

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rdata = '0;
    case (wb_adr_i[4:2])
      AdrStatus: rdata = status_w;
      AdrRange:  rdata = range_q;
      AdrCfg:    rdata = cfg_q;
      AdrResult: rdata = fifo_empty ? 32'h0 : {head[25:10], 6'b0, head[9:0]};
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_now) mem[wr_ptr_q] <= {hits_q, code_q};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= StIdle;
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= '0;
      adr_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      dat_q        <= '0;
      pop_pend_q   <= 1'b0;
      range_q      <= '0;
      cfg_q        <= '0;
      done_q       <= 1'b0;
      range_err_q  <= 1'b0;
      code_q       <= '0;
      run_stop_q   <= '0;
      run_step_q   <= '0;
      run_shots_q  <= '0;
      hits_q       <= '0;
      shot_q       <= '0;
      settle_cnt_q <= '0;
      phase_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      delay_code_o <= '0;
      stb_o        <= 1'b0;
    end else begin
      wb_ack_o <= req;
      if (req) begin
        adr_q      <= wb_adr_i[4:2];
        we_q       <= wb_we_i;
        sel_q      <= wb_sel_i;
        dat_q      <= wb_dat_i;
        pop_pend_q <= !wb_we_i && (wb_adr_i[4:2] == AdrResult) && !fifo_empty;
        wb_dat_o   <= wb_we_i ? 32'h0 : rdata;
      end else begin
        wb_dat_o <= '0;
      end

      if (wr_now && adr_q == AdrRange) range_q <= merge(range_q, dat_q, sel_q) & RangeMask;
      if (wr_now && adr_q == AdrCfg)   cfg_q   <= merge(cfg_q, dat_q, sel_q) & CfgMask;

      if (push_now) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_now)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_now, pop_now})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (abort_now) begin
        state_q <= StIdle;
        stb_o   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_now) begin
              done_q      <= 1'b0;
              range_err_q <= 1'b0;
              if (range_q[9:0] > range_q[25:16]) begin
                range_err_q <= 1'b1;
                done_q      <= 1'b1;
              end else begin
                run_stop_q   <= range_q[25:16];
                run_step_q   <= (cfg_q[9:0] == '0) ? 10'd1 : cfg_q[9:0];
                run_shots_q  <= cfg_q[31:16];
                code_q       <= range_q[9:0];
                delay_code_o <= range_q[9:0];
                settle_cnt_q <= '0;
                state_q      <= StSettle;
              end
            end
          end
          StSettle: begin
            if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
              hits_q  <= '0;
              shot_q  <= '0;
              phase_q <= '0;
              if (run_shots_q == '0) begin
                state_q <= StPush;
              end else begin
                state_q <= StShot;
                stb_o   <= 1'b1;
              end
            end else begin
              settle_cnt_q <= settle_cnt_q + SW'(1);
            end
          end
          StShot: begin
            if (phase_q == PW'(CMP_LATENCY) && cmp_i && hits_q != 16'hFFFF) begin
              hits_q <= hits_q + 16'd1;
            end
            if (phase_q == PW'(Period - 1)) begin
              phase_q <= '0;
              shot_q  <= shot_q + 16'd1;
              if ({1'b0, shot_q} + 17'd1 == {1'b0, run_shots_q}) begin
                state_q <= StPush;
                stb_o   <= 1'b0;
              end else begin
                stb_o <= 1'b1;
              end
            end else begin
              phase_q <= phase_inc;
              stb_o   <= (phase_inc < PW'(STB_HIGH_CYCLES));
            end
          end
          StPush: begin
            if (push_now) state_q <= StNext;
          end
          StNext: begin
            if (next_code > {1'b0, run_stop_q}) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              code_q       <= next_code[9:0];
              delay_code_o <= next_code[9:0];
              settle_cnt_q <= '0;
              state_q      <= StSettle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/mu_sweep_ctrl.md
Name: mu_sweep_ctrl

Overview:
Wishbone-slave sequencer for one delay-line/comparator channel of the measure path. Steps the delay code from START to STOP by STEP. At each point it fires N strobe pulses, counts comparator hits, and pushes a (code, hits) record into a result FIFO that the CPU drains over Wishbone. It sits on a crossbar slave port beside the measure unit and drives the delay-line code and strobe directly.

Parameters:
SETTLE_CYCLES, 16, idle cycles after each code change before the first strobe (>=1)
STB_HIGH_CYCLES, 4, strobe high time; shot period = 2*STB_HIGH_CYCLES (>=1)
CMP_LATENCY, 2, cycle within a shot (0 = strobe rise) at which cmp_i is sampled; must be < 2*STB_HIGH_CYCLES
FIFO_DEPTH, 16, result FIFO entries (power of 2, 2..256)

Ports:
wb_clk_i  in  1  clock; all logic in this domain
wb_rst_i  in  1  synchronous reset, active-high
wb_adr_i  in  32  byte address; only [4:2] decoded
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_we_i  in  1  write enable
wb_sel_i  in  4  byte lane enables
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  tied 0
wb_stall_o  out  1  tied 0
delay_code_o  out  10  delay-line code
stb_o  out  1  strobe to delay line
cmp_i  in  1  comparator output, already synchronised to wb_clk_i
busy_o  out  1  sweep in progress (mirror of STATUS.busy)

Behaviour:
- Reset: wb_ack_o=0, wb_dat_o=0, delay_code_o=0, stb_o=0, busy_o=0. All registers, FIFO pointers, done and range_err are cleared. FSM=IDLE. Reset mid-sweep aborts immediately; no record is pushed.
- WB: classic cycle. wb_ack_o pulses 1 cycle, asserted the cycle after cyc&stb&!ack. Writes honour wb_sel_i per byte. Writes to read-only or undecoded words are acked and ignored. Undecoded reads return 0.
- Register map (word index adr[4:2]):
  0 CTRL (W): bit0 START, bit1 ABORT; self-clearing, reads 0.
  1 STATUS (R): bit0 busy, bit1 done, bit2 fifo_empty, bit3 fifo_full, bit4 range_err, [15:8] fifo count.
  2 RANGE (RW): [9:0] start code, [25:16] stop code.
  3 CFG (RW): [9:0] step (0 behaves as 1), [31:16] shots per point.
  4 RESULT (R): [9:0] code, [31:16] hits. A read pops one record on its ack cycle. A read while empty returns 0 and does not pop.
- START in IDLE: clears done and range_err.
  - If start>stop: sets range_err and done, stays IDLE, pushes nothing.
  - Otherwise: code:=start, go SETTLE.
  - START while busy is ignored.
- ABORT: from any non-IDLE state, IDLE on the next cycle. stb_o=0, current point discarded, done not set. FIFO contents kept.
- FSM:
  - IDLE: busy=0.
  - SETTLE: delay_code_o=code; wait SETTLE_CYCLES; hits:=0, shot:=0.
    - If shots==0, go PUSH directly.
    - Otherwise go SHOT.
  - SHOT: phase counter 0..2*STB_HIGH_CYCLES-1. stb_o=1 for phase<STB_HIGH_CYCLES. At phase==CMP_LATENCY, if cmp_i then hits+=1, saturating at 0xFFFF. At the end of the period, shot+=1; if shot==shots go PUSH, else next shot. No gap between shots.
  - PUSH: if FIFO not full, write {hits,code} and go NEXT. If full, hold here: stb_o=0, code held, busy=1.
  - NEXT: compute code+step in 11 bits. If result>stop, set done and go IDLE; otherwise code:=result and go SETTLE.
- First strobe rises SETTLE_CYCLES+1 cycles after the START ack cycle.
- FIFO: a simultaneous push and pop when full is allowed; count is unchanged. Count width is clog2(FIFO_DEPTH)+1, zero-extended into [15:8].
- delay_code_o holds the last code after done or abort. It changes only in SETTLE entry.
- RANGE and CFG writes during busy take effect only at the next START; the sequencer latches them at START.

Test Plan:
- start=10, stop=14, step=2, shots=8, cmp_i=1 -> FIFO holds (10,8),(12,8),(14,8); done=1, busy=0; delay_code_o=14; 24 stb_o pulses total.
- cmp_i toggled high only during odd shots, start=stop=5, shots=6 -> single record (5,3).
- FIFO_DEPTH=16, start=0, stop=19, step=1, shots=1, no reads -> 16 records, FSM stalls with fifo_full=1, busy=1, stb_o=0. Reading 4 records lets the sweep complete with 20 records total popped, in order 0..19.
- ABORT written during the SHOT of code 12 in a 10..20 sweep -> busy=0 within 2 cycles after ack, stb_o=0, done=0, FIFO holds only the 10 and 11 records.
- start=30, stop=20 -> range_err=1, done=1, no strobes. RESULT read when empty returns 0 and count stays 0. step=0 behaves as step=1.
- Assert wb_rst_i mid-SETTLE -> next cycle all outputs at reset values, STATUS reads 0x0004 (fifo_empty only).
